// File: rtl/dsp_pkg.sv
// Shared DSP types for the up/down-conversion sample paths: sample type,
// full-scale limits, the run-state enum and the phase-counter width helper.
package dsp_pkg;

  localparam int SAMPLE_DW = 16;

  typedef logic signed [SAMPLE_DW-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_DW-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_DW-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int phase_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_scale.sv
// Constant multiply by L with saturation to the signed DW-bit range.
// Purely combinational; shared by the interpolator and decimator paths.
module sat_scale #(
  parameter int DW = 16,
  parameter int L  = 3
) (
  input  logic [DW-1:0] x_i,
  output logic [DW-1:0] y_o
);

  // One guard bit above DW+clog2(L) keeps the full product exact.
  localparam int PW = DW + $clog2(L) + 1;

  localparam logic signed [PW-1:0] L_S   = PW'(L);
  localparam logic signed [PW-1:0] MAX_S = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_S = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] prod;

  assign x_ext = {{(PW-DW){x_i[DW-1]}}, x_i};
  assign prod  = x_ext * L_S;

  always_comb begin
    y_o = prod[DW-1:0];
    if (prod > MAX_S) begin
      y_o = MAX_S[DW-1:0];
    end else if (prod < MIN_S) begin
      y_o = MIN_S[DW-1:0];
    end
  end

endmodule

// File: rtl/interpolation_3.sv
// Integer-factor upsampler (sample-and-hold or zero-stuff) for the DUC path.
// Optional INTERP_ZSTUFF_GAIN_EN scales zero-stuffed samples by L on load.
module interpolation_3
  import dsp_pkg::*;
#(
  parameter int L    = 3,
  parameter int HOLD = 1,
  parameter int DW   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             data_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DW-1:0]             data_out,
  output logic                      out_valid,
  output logic [phase_width(L)-1:0] phase,
  output logic                      underrun
);

  localparam int            PW   = phase_width(L);
  localparam logic [PW-1:0] LAST = PW'(L - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [DW-1:0] sample_q, sample_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          out_valid_q, out_valid_d;
  logic          underrun_q, underrun_d;
  logic [DW-1:0] load_val;
  logic          accept;

`ifdef INTERP_ZSTUFF_GAIN_EN
  generate
    if (HOLD == 0) begin : g_gain
      logic [DW-1:0] scaled;
      sat_scale #(.DW(DW), .L(L)) u_sat_scale (
        .x_i (data_in),
        .y_o (scaled)
      );
      assign load_val = scaled;
    end else begin : g_no_gain
      assign load_val = data_in;
    end
  endgenerate
`else
  assign load_val = data_in;
`endif

  // Ready depends only on state/phase so the source may gate valid on it.
  assign in_ready = !rst && ((state_q == IDLE) || (phase_q == LAST));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sample_d    = sample_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    underrun_d  = underrun_q;

    if (accept) begin
      state_d     = RUN;
      phase_d     = '0;
      sample_d    = load_val;
      data_out_d  = load_val;
      out_valid_d = 1'b1;
    end else if (state_q == RUN) begin
      if (phase_q == LAST) begin
        // Source missed its slot: drop back to IDLE and flag it.
        state_d     = IDLE;
        phase_d     = '0;
        data_out_d  = '0;
        out_valid_d = 1'b0;
        underrun_d  = 1'b1;
      end else begin
        phase_d     = phase_q + 1'b1;
        data_out_d  = (HOLD != 0) ? sample_q : '0;
        out_valid_d = 1'b1;
      end
    end else begin
      phase_d     = '0;
      data_out_d  = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      sample_q    <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sample_q    <= sample_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_interpolation_3.sv
// Directed bench for interpolation_3: a hold-mode and a zero-stuff instance
// (L=3), expected outputs queued per driven cycle and checked one cycle later.
module tb_interpolation_3;

  typedef struct {
    logic [15:0] d;
    logic        v;
    logic [1:0]  ph;
    logic        ur;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;  // 0 = hold instance, 1 = zero-stuff instance
  logic [15:0] din = '0;
  logic        vin = 1'b0;

  logic [15:0] a_din, b_din, a_dout, b_dout;
  logic        a_vin, b_vin, a_rdy, b_rdy, a_ov, b_ov, a_ur, b_ur;
  logic [1:0]  a_ph, b_ph;

  logic [15:0] o_dout;
  logic        o_rdy, o_ov, o_ur;
  logic [1:0]  o_ph;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign a_din = din;
  assign b_din = din;
  assign a_vin = vin && !sel;
  assign b_vin = vin && sel;

  assign o_dout = sel ? b_dout : a_dout;
  assign o_rdy  = sel ? b_rdy  : a_rdy;
  assign o_ov   = sel ? b_ov   : a_ov;
  assign o_ur   = sel ? b_ur   : a_ur;
  assign o_ph   = sel ? b_ph   : a_ph;

  interpolation_3 #(.L(3), .HOLD(1), .DW(16)) u_hold (
    .clk (clk), .rst (rst), .data_in (a_din), .in_valid (a_vin),
    .in_ready (a_rdy), .data_out (a_dout), .out_valid (a_ov),
    .phase (a_ph), .underrun (a_ur)
  );

  interpolation_3 #(.L(3), .HOLD(0), .DW(16)) u_zstuff (
    .clk (clk), .rst (rst), .data_in (b_din), .in_valid (b_vin),
    .in_ready (b_rdy), .data_out (b_dout), .out_valid (b_ov),
    .phase (b_ph), .underrun (b_ur)
  );

  // Phase-0 value of a zero-stuffed sample: raw, or the gain-scaled literal.
  function automatic logic [15:0] zs(input int raw, input int scaled);
`ifdef INTERP_ZSTUFF_GAIN_EN
    return 16'(scaled);
`else
    return 16'(raw);
`endif
  endfunction

  task automatic push(input int d, input logic v, input int ph, input logic ur);
    exp_t e;
    e.d  = 16'(d);
    e.v  = v;
    e.ph = 2'(ph);
    e.ur = ur;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input int obs, input int req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
    end
  endtask

  // Drive one cycle (called just after a negedge) and check the result.
  task automatic step(input string tag, input logic v, input int d, input logic rdy,
                      input int ed, input logic ev, input int eph, input logic eur);
    exp_t e;
    vin = v;
    din = 16'(d);
    push(ed, ev, eph, eur);
    #1;
    chk({tag, ".in_ready"}, int'(o_rdy), int'(rdy));
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s.queue observed=empty required=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".data_out"}, int'($signed(o_dout)), int'($signed(e.d)));
      chk({tag, ".out_valid"}, int'(o_ov), int'(e.v));
      chk({tag, ".phase"}, int'(o_ph), int'(e.ph));
      chk({tag, ".underrun"}, int'(o_ur), int'(e.ur));
    end
    $display("step %-12s vin=%0b din=%0d -> dout=%0d ov=%0b ph=%0d ur=%0b",
             tag, v, $signed(16'(d)), $signed(o_dout), o_ov, o_ph, o_ur);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset: ready low during reset, all outputs cleared.
    rst = 1'b1;
    step("rst", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    rst = 1'b0;

    // Sample-and-hold, source always valid.
    step("h100", 1'b1, 100, 1'b1, 100, 1'b1, 0, 1'b0);
    step("h100p1", 1'b1, -200, 1'b0, 100, 1'b1, 1, 1'b0);
    step("h100p2", 1'b1, -200, 1'b0, 100, 1'b1, 2, 1'b0);
    step("hm200", 1'b1, -200, 1'b1, -200, 1'b1, 0, 1'b0);
    step("hm200p1", 1'b1, 300, 1'b0, -200, 1'b1, 1, 1'b0);
    step("hm200p2", 1'b1, 300, 1'b0, -200, 1'b1, 2, 1'b0);
    step("h300", 1'b1, 300, 1'b1, 300, 1'b1, 0, 1'b0);
    step("h300p1", 1'b0, 0, 1'b0, 300, 1'b1, 1, 1'b0);
    step("h300p2", 1'b0, 0, 1'b0, 300, 1'b1, 2, 1'b0);
    // Missed slot at phase 2 -> underrun, back to IDLE.
    step("under", 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b1);
    step("restart7", 1'b1, 7, 1'b1, 7, 1'b1, 0, 1'b1);
    // Backpressure: 55 held valid through phases 0-1, taken only at phase 2.
    step("bp_p1", 1'b1, 55, 1'b0, 7, 1'b1, 1, 1'b1);
    step("bp_p2", 1'b1, 55, 1'b0, 7, 1'b1, 2, 1'b1);
    step("bp_take", 1'b1, 55, 1'b1, 55, 1'b1, 0, 1'b1);
    step("h55p1", 1'b0, 0, 1'b0, 55, 1'b1, 1, 1'b1);
    // Reset mid-run at phase 1.
    rst = 1'b1;
    step("midrst", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    rst = 1'b0;
    step("postrst", 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0);

    // Zero-stuff instance.
    sel = 1'b1;
    step("z_idle", 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0);
    step("z1000", 1'b1, 1000, 1'b1, zs(1000, 3000), 1'b1, 0, 1'b0);
    step("z1000p1", 1'b1, -1000, 1'b0, 0, 1'b1, 1, 1'b0);
    step("z1000p2", 1'b1, -1000, 1'b0, 0, 1'b1, 2, 1'b0);
    step("zm1000", 1'b1, -1000, 1'b1, zs(-1000, -3000), 1'b1, 0, 1'b0);
    step("zm1000p1", 1'b1, 12000, 1'b0, 0, 1'b1, 1, 1'b0);
    step("zm1000p2", 1'b1, 12000, 1'b0, 0, 1'b1, 2, 1'b0);
    step("z12000", 1'b1, 12000, 1'b1, zs(12000, 32767), 1'b1, 0, 1'b0);
    step("z12000p1", 1'b1, 11000, 1'b0, 0, 1'b1, 1, 1'b0);
    step("z12000p2", 1'b1, 11000, 1'b0, 0, 1'b1, 2, 1'b0);
    step("z11000", 1'b1, 11000, 1'b1, zs(11000, 32767), 1'b1, 0, 1'b0);
    step("z11000p1", 1'b1, -5000, 1'b0, 0, 1'b1, 1, 1'b0);
    step("z11000p2", 1'b1, -5000, 1'b0, 0, 1'b1, 2, 1'b0);
    step("zm5000", 1'b1, -5000, 1'b1, zs(-5000, -15000), 1'b1, 0, 1'b0);
    step("zm5000p1", 1'b1, -12000, 1'b0, 0, 1'b1, 1, 1'b0);
    step("zm5000p2", 1'b1, -12000, 1'b0, 0, 1'b1, 2, 1'b0);
    step("zm12000", 1'b1, -12000, 1'b1, zs(-12000, -32768), 1'b1, 0, 1'b0);
    step("zm12000p1", 1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0);
    step("zm12000p2", 1'b0, 0, 1'b0, 0, 1'b1, 2, 1'b0);
    step("z_under", 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain observed=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
